// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-stage next-PC generator.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pred_next;
        logic            pred_taken;
    } fq_entry_t;
endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: predictor, icache, hazard and execute-resolution signals of the fetch PC generator.
interface fetch_pc_gen_if #(parameter int DATA_WIDTH = fetch_pkg::XLEN);
    logic                  icache_ready;
    logic                  stall;
    logic                  predict_taken;
    logic [DATA_WIDTH-1:0] branch_target;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_actual_next;
    logic [DATA_WIDTH-1:0] PC_f;
    logic                  fetch_req;
    logic                  flush;
    logic [31:0]           mispredict_cnt;
    logic [31:0]           resolve_cnt;
    logic                  err_underflow;
    modport master (
        output icache_ready, stall, predict_taken, branch_target, ex_valid, ex_actual_next,
        input  PC_f, fetch_req, flush, mispredict_cnt, resolve_cnt, err_underflow
    );
    modport slave (
        input  icache_ready, stall, predict_taken, branch_target, ex_valid, ex_actual_next,
        output PC_f, fetch_req, flush, mispredict_cnt, resolve_cnt, err_underflow
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-flight fetch FIFO; pointers carry an extra wrap bit so count covers 0..DEPTH.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fq_entry_t              din,
    output fq_entry_t              dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    fq_entry_t   mem_q [DEPTH];
    logic        do_push, do_pop;

    always_comb begin
        count   = wr_q - rd_q;
        full    = count == (AW+1)'(DEPTH);
        empty   = count == '0;
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = clear ? '0 : wr_q + (AW+1)'(do_push);
        rd_d    = clear ? '0 : rd_q + (AW+1)'(do_pop);
        dout    = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register, predicted next-PC mux and execute-time misprediction redirect.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH  = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int                    QUEUE_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    fetch_pc_gen_if.slave bus
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, pred_next;
    logic [31:0]           mis_q, mis_d, res_q, res_d;
    logic                  err_q, err_d;
    logic                  pop, mispredict, fetch_req, accept;
    logic                  fq_full, fq_empty;
    logic [CW-1:0]         fq_count;
    fq_entry_t             head, entry;
    logic                  unused_head;

    always_comb begin
        pred_next  = bus.predict_taken ? bus.branch_target : pc_q + PC_INC;
        pop        = bus.ex_valid && !fq_empty;
        mispredict = pop && (head.pred_next != bus.ex_actual_next);
        // Redirect beats everything: no request, so no push, in the flush cycle.
        fetch_req  = !fq_full && !mispredict;
        accept     = fetch_req && bus.icache_ready && !bus.stall;
        entry      = '{pc: pc_q, pred_next: pred_next, pred_taken: bus.predict_taken};
        pc_d       = mispredict ? bus.ex_actual_next : accept ? pred_next : pc_q;
        res_d      = (pop && res_q != '1) ? res_q + 32'd1 : res_q;
        mis_d      = (mispredict && mis_q != '1) ? mis_q + 32'd1 : mis_q;
        err_d      = err_q | (bus.ex_valid && fq_count == '0);
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .clear (mispredict),
        .din   (entry),
        .dout  (head),
        .count (fq_count),
        .full  (fq_full),
        .empty (fq_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            mis_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    assign unused_head        = ^{head.pc, head.pred_taken};
    assign bus.PC_f           = pc_q;
    assign bus.fetch_req      = fetch_req;
    assign bus.flush          = mispredict;
    assign bus.mispredict_cnt = mis_q;
    assign bus.resolve_cnt    = res_q;
    assign bus.err_underflow  = err_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed literal checks plus randomized traffic against a queue-based reference model.
module tb_fetch_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    fetch_pc_gen_if bus ();

    fetch_pc_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of predicted successors, one entry per accepted fetch.
    logic [31:0] m_q[$];
    logic [31:0] m_pc, m_mis, m_res, m_pn;
    logic        m_err, m_mism, m_acc;

    always @(negedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_pc  = 32'h0;
            m_mis = 0;
            m_res = 0;
            m_err = 0;
            chk("rst_pc", bus.PC_f, 32'h0);
            chk("rst_flush", bus.flush, 0);
            chk("rst_req", bus.fetch_req, 1);
            chk("rst_cnts", bus.mispredict_cnt | bus.resolve_cnt, 0);
            chk("rst_err", bus.err_underflow, 0);
        end else begin
            m_mism = bus.ex_valid && m_q.size() > 0 && m_q[0] !== bus.ex_actual_next;
            chk("pc", bus.PC_f, m_pc);
            chk("flush", bus.flush, m_mism);
            chk("fetch_req", bus.fetch_req, m_q.size() < 4 && !m_mism);
            chk("mispredict_cnt", bus.mispredict_cnt, m_mis);
            chk("resolve_cnt", bus.resolve_cnt, m_res);
            chk("err_underflow", bus.err_underflow, m_err);
            m_acc = m_q.size() < 4 && !m_mism && bus.icache_ready && !bus.stall;
            m_pn  = bus.predict_taken ? bus.branch_target : m_pc + 32'd4;
            if (bus.ex_valid && m_q.size() == 0) m_err = 1;
            if (m_mism) begin
                m_q.delete();
                m_pc  = bus.ex_actual_next;
                m_mis = (m_mis == 32'hFFFF_FFFF) ? m_mis : m_mis + 1;
                m_res = (m_res == 32'hFFFF_FFFF) ? m_res : m_res + 1;
            end else begin
                if (bus.ex_valid && m_q.size() > 0) begin
                    void'(m_q.pop_front());
                    m_res = (m_res == 32'hFFFF_FFFF) ? m_res : m_res + 1;
                end
                if (m_acc) begin
                    m_q.push_back(m_pn);
                    m_pc = m_pn;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.icache_ready   = 1;
        bus.stall          = 0;
        bus.predict_taken  = 0;
        bus.branch_target  = 0;
        bus.ex_valid       = 0;
        bus.ex_actual_next = 0;
        step();
        step();
        rst = 1;
        @(negedge clk);
        chk("lit_pc0", bus.PC_f, 32'h0);
        chk("lit_req0", bus.fetch_req, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            @(negedge clk);
            chk("lit_seq_pc", bus.PC_f, 32'(4 * i));
        end
        chk("lit_full_req", bus.fetch_req, 0);
        step();
        bus.ex_valid = 1; bus.ex_actual_next = 32'h4;
        @(negedge clk);
        chk("lit_full_pop_req", bus.fetch_req, 0);
        chk("lit_match_flush", bus.flush, 0);
        step();
        bus.ex_valid = 0; bus.predict_taken = 1; bus.branch_target = 32'h40;
        @(negedge clk);
        chk("lit_reenable_req", bus.fetch_req, 1);
        chk("lit_res1", bus.resolve_cnt, 1);
        chk("lit_mis0", bus.mispredict_cnt, 0);
        step();
        bus.predict_taken = 0; bus.ex_valid = 1; bus.ex_actual_next = 32'h8;
        @(negedge clk);
        chk("lit_taken_pc", bus.PC_f, 32'h40);
        step();
        bus.ex_actual_next = 32'h100; bus.stall = 1;
        @(negedge clk);
        chk("lit_mis_flush", bus.flush, 1);
        chk("lit_res2", bus.resolve_cnt, 2);
        step();
        bus.ex_valid = 0;
        @(negedge clk);
        chk("lit_flush_once", bus.flush, 0);
        chk("lit_redirect_pc", bus.PC_f, 32'h100);
        chk("lit_mis1", bus.mispredict_cnt, 1);
        chk("lit_redirect_req", bus.fetch_req, 1);
        step();
        bus.ex_valid = 1; bus.ex_actual_next = 32'h55;
        @(negedge clk);
        chk("lit_uflow_flush", bus.flush, 0);
        step();
        bus.ex_valid = 0;
        @(negedge clk);
        chk("lit_uflow_err", bus.err_underflow, 1);
        chk("lit_uflow_res", bus.resolve_cnt, 3);
        chk("lit_uflow_mis", bus.mispredict_cnt, 1);
        step();
        bus.stall = 0; bus.predict_taken = 1; bus.branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("lit_err_sticky", bus.err_underflow, 1);
        step();
        bus.predict_taken = 0;
        @(negedge clk);
        chk("lit_pc_top", bus.PC_f, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        chk("lit_pc_wrap", bus.PC_f, 32'h0);
        step();
        bus.stall = 1;
        #2 rst = 0;
        #1;
        chk("lit_async_pc", bus.PC_f, 32'h0);
        chk("lit_async_req", bus.fetch_req, 1);
        chk("lit_async_err", bus.err_underflow, 0);
        chk("lit_async_res", bus.resolve_cnt, 0);
        step();
        bus.stall = 0;
        rst = 1;
        repeat (3000) begin
            step();
            bus.icache_ready   = $urandom_range(0, 3) != 0;
            bus.stall          = $urandom_range(0, 4) == 0;
            bus.predict_taken  = $urandom_range(0, 2) == 0;
            bus.branch_target  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            bus.ex_valid       = $urandom_range(0, 9) < 4;
            bus.ex_actual_next = (m_q.size() > 0 && $urandom_range(0, 3) != 0) ? m_q[0] : ($urandom & 32'hFFFF_FFFC);
        end
        step();
        bus.ex_valid = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator for the pipelined-plus-cache core. It owns the fetch PC register, selects the next PC from the dynamic branch predictor's taken/target output, and issues fetch requests to the instruction cache. It tracks every in-flight fetch's predicted successor in a small queue, and compares each against the actual next PC reported by execute. On a mismatch it redirects fetch, clears the queue and raises a one-cycle pipeline flush.

## Interface
- DATA_WIDTH, 32, address/data width
- RESET_PC, 32'h0000_0000, PC_f value after reset
- QUEUE_DEPTH, 4, maximum in-flight fetches awaiting resolution (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- icache_ready  in  1  instruction cache accepts a request this cycle
- stall  in  1  hazard-unit freeze of fetch
- predict_taken  in  1  predictor decision for current PC_f (combinational)
- branch_target  in  DATA_WIDTH  predictor target for current PC_f
- ex_valid  in  1  an instruction leaves execute this cycle (in program order)
- ex_actual_next  in  DATA_WIDTH  resolved successor PC of that instruction
- PC_f  out  DATA_WIDTH  current fetch PC (registered)
- fetch_req  out  1  request to instruction cache
- flush  out  1  kill all younger instructions in F/D/E
- mispredict_cnt  out  32  resolved mispredictions, saturating
- resolve_cnt  out  32  resolved instructions, saturating
- err_underflow  out  1  sticky: ex_valid seen with empty queue

## Operation
- Fetch is accepted when fetch_req && icache_ready && !stall.
- fetch_req = (count < QUEUE_DEPTH) && !flush.
- Predicted next: pred_next = predict_taken ? branch_target : PC_f + 4, with 32-bit wrap-around; 32'hFFFF_FFFC + 4 = 0.
- On accept, push {PC_f, pred_next, predict_taken} and load PC_f ← pred_next.
- On ex_valid with a non-empty queue, pop the head and compare head.pred_next against ex_actual_next.
  - Match: resolve_cnt += 1.
  - Mismatch: flush = 1 (combinational, same cycle), PC_f ← ex_actual_next at the next edge, queue cleared, both counters += 1.
- Redirect has priority over stall, icache_ready and any simultaneous push. The push in a flush cycle is dropped.
- Simultaneous push and pop with no mismatch: count unchanged; pointers both advance.
- ex_valid with an empty queue: no pop, no flush, counters unchanged, err_underflow ← 1 until reset.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- When stall is high or icache_ready is low, PC_f holds and nothing is pushed. Pops and redirects still proceed.

## Timing
- Reset (async assert, sync-safe deassert): PC_f = RESET_PC, queue empty (count = 0), flush = 0, counters = 0, err_underflow = 0. fetch_req = 1 in the first cycle after reset.
- Next-PC latency is one cycle: the accept at edge N presents pred_next on PC_f after edge N.
- Redirect latency: mismatch in cycle N → flush high in cycle N only → PC_f = ex_actual_next after edge N, fetch_req high in N+1.
- Queue full (count = QUEUE_DEPTH): fetch_req is low. A pop in that cycle re-enables fetch_req in the next cycle, not the same one.
- Reset mid-operation drops all queue contents immediately; no flush pulse is generated.

## Structure
- Package fetch_pkg holds:
  - typedef fq_entry_t (packed): pc, pred_next, pred_taken
  - localparam PC_INC = 4
  - default RESET_PC constant
- Sub-module fetch_queue: synchronous FIFO of fq_entry_t with push, pop, clear, count, full and empty. Depth is QUEUE_DEPTH, with wrap-around pointers and an extra count bit. Clear has priority over push and pop.
- The top level holds the PC register, the next-PC mux, the comparator, the counters and the error flag.

## Test plan
- Reset, icache_ready = 1, predict_taken = 0 for 4 cycles → PC_f sequence 0, 4, 8, C, 10. fetch_req drops after 4 pushes with no pops.
- At PC_f = 8: predict_taken = 1, branch_target = 40 → PC_f = 40 next cycle, pushed entry pred_next = 40.
- ex_valid with ex_actual_next = 40 against head pred_next = 40 → no flush, resolve_cnt = 1, mispredict_cnt = 0.
- ex_valid with ex_actual_next = 100 against head pred_next = C, with stall = 1 and a simultaneous accept attempt:
  - flush high for exactly one cycle
  - PC_f = 100 next cycle, queue count = 0
  - mispredict_cnt = 1
- Queue full, pop and push requested in the same cycle → fetch_req low that cycle, high the next cycle, count = 3.
- ex_valid on an empty queue → err_underflow = 1 and stays high. Counters unchanged, no flush.
- Assert rst mid-run with count = 3 → all outputs immediately at reset values.
